// File: rtl/msu_coef_normalizer.sv
// msu_coef_normalizer: serial carry propagation of redundant squaring coefficients into a canonical integer.
// Optional MSU_NORM_ITER_COUNT_EN adds a 64-bit handshake counter output iter_count.
module msu_coef_normalizer #(
    parameter int MOD_LEN            = 1024,
    parameter int WORD_LEN           = 16,
    parameter int COEF_BITS          = 17,
    parameter int FIELD_BITS         = 32,
    parameter int REDUNDANT_ELEMENTS = 2,
    parameter int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
    parameter int WORDS_PER_CYCLE    = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [NUM_ELEMENTS*FIELD_BITS-1:0] sq_in_coefs,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_ELEMENTS*WORD_LEN-1:0] result,
    output logic [MOD_LEN-1:0]               mod_out,
    output logic                             hi_nonzero,
    output logic                             overflow,
    output logic                             overrun,
    output logic                             busy
`ifdef MSU_NORM_ITER_COUNT_EN
    ,
    output logic [63:0]                      iter_count
`endif
);
    localparam int N_BEATS = NUM_ELEMENTS / WORDS_PER_CYCLE;
    localparam int BW      = N_BEATS > 1 ? $clog2(N_BEATS) : 1;
    localparam int KW      = NUM_ELEMENTS > 1 ? $clog2(NUM_ELEMENTS) : 1;
    localparam int SW      = COEF_BITS + 2;
    localparam int LO      = MOD_LEN / WORD_LEN;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    if (NUM_ELEMENTS % WORDS_PER_CYCLE != 0) begin : g_bad_cfg
        $error("NUM_ELEMENTS must be a multiple of WORDS_PER_CYCLE");
    end

    state_t                                 state_q, state_d;
    logic [BW-1:0]                          beat_q, beat_d;
    logic [2:0]                             carry_q, carry_d, c;
    logic [NUM_ELEMENTS-1:0][COEF_BITS-1:0] coef_q, coef_d;
    logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0]  result_q, result_d;
    logic                                   overflow_q, overflow_d;
    logic                                   hi_q, hi_d;
    logic                                   overrun_q, overrun_d;
    logic                                   valid_q, valid_d;
    logic [SW-1:0]                          s;
    logic [KW-1:0]                          k;

    // Field bits above COEF_BITS carry no information and are dropped.
    logic [NUM_ELEMENTS-1:0] unused_field_hi;
    for (genvar j = 0; j < NUM_ELEMENTS; j++) begin : g_unused
        assign unused_field_hi[j] = ^sq_in_coefs[j*FIELD_BITS+COEF_BITS +: FIELD_BITS-COEF_BITS];
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        carry_d    = carry_q;
        coef_d     = coef_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        hi_d       = hi_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q | (in_valid && state_q != IDLE);
        c          = carry_q;
        s          = '0;
        k          = '0;
        if (state_q == IDLE && in_valid) begin
            for (int j = 0; j < NUM_ELEMENTS; j++)
                coef_d[j] = sq_in_coefs[j*FIELD_BITS +: COEF_BITS];
            carry_d = '0;
            beat_d  = '0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            // Carry ripples through the words of one beat, then is registered.
            for (int i = 0; i < WORDS_PER_CYCLE; i++) begin
                k           = KW'(int'(beat_q) * WORDS_PER_CYCLE + i);
                s           = SW'(coef_q[k]) + SW'(c);
                result_d[k] = s[WORD_LEN-1:0];
                c           = 3'(s >> WORD_LEN);
            end
            carry_d = c;
            beat_d  = beat_q + 1'b1;
            if (beat_q == BW'(N_BEATS - 1)) begin
                overflow_d = c != 3'd0;
                hi_d       = (c != 3'd0) | (|result_d[NUM_ELEMENTS-1:LO]);
                valid_d    = 1'b1;
                state_d    = DONE;
            end
        end else if (state_q == DONE && out_ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            carry_q    <= '0;
            coef_q     <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            hi_q       <= 1'b0;
            overrun_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            carry_q    <= carry_d;
            coef_q     <= coef_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            hi_q       <= hi_d;
            overrun_q  <= overrun_d;
            valid_q    <= valid_d;
        end
    end

`ifdef MSU_NORM_ITER_COUNT_EN
    logic [63:0] iter_q;
    always_ff @(posedge clk) begin
        if (reset) iter_q <= '0;
        else if (valid_q && out_ready) iter_q <= iter_q + 64'd1;
    end
    assign iter_count = iter_q;
`endif

    assign out_valid  = valid_q;
    assign result     = result_q;
    assign mod_out    = result_q[LO-1:0];
    assign hi_nonzero = hi_q;
    assign overflow   = overflow_q;
    assign overrun    = overrun_q;
    assign busy       = state_q != IDLE;
endmodule
